arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester_pkg.sv | 15 +
 rtl/arb_req_chan.sv | 113 +++++++++++
 rtl/arb_requester.sv | 55 +++++
 tb/tb_arb_requester.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_requester_pkg.sv
// Shared types and defaults for the two-channel arbiter requester.
// Channel state is one-hot so each phase decodes from a single flop.
package arb_requester_pkg;

  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_OWN  = 4'b0100,
    ST_REL  = 4'b1000
  } chan_state_e;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: takes a burst command, requests the arbiter, strobes one
// beat per granted cycle, then waits for the grant to drop before going idle.
module arb_req_chan
  import arb_requester_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             gnt,
  output logic             req,
  output logic             beat,
  output logic             done,
  output logic             err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  chan_state_e       state_q, state_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      wait_q     <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      wait_q     <= wait_d;
      req_q      <= req_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          beat_cnt_d = cmd_len;
          wait_d     = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          wait_d  = '0;
          state_d = ST_OWN;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_OWN: begin
        // Counter holds beats still owed after this one; zero means last beat.
        if (!gnt) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (beat_cnt_q == '0) begin
          wait_d  = '0;
          state_d = ST_REL;
        end else begin
          beat_cnt_d = beat_cnt_q - 1'b1;
        end
      end
      ST_REL: begin
        if (!gnt) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Request is registered alongside the state it belongs to.
    req_d = (state_d == ST_REQ) || (state_d == ST_OWN);
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    beat      = (state_q == ST_OWN) && gnt;
    req       = req_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: rtl/arb_requester.sv
// Two independent burst requesters sharing a 2-way arbiter; each channel
// proceeds only on its own grant.
module arb_requester
  import arb_requester_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid0,
  input  logic [LEN_W-1:0] cmd_len0,
  output logic             cmd_ready0,
  input  logic             cmd_valid1,
  input  logic [LEN_W-1:0] cmd_len1,
  output logic             cmd_ready1,
  input  logic             gnt0,
  input  logic             gnt1,
  output logic             req0,
  output logic             req1,
  output logic             beat0,
  output logic             beat1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1
);

  arb_req_chan #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) u_chan0 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid0),
    .cmd_len   (cmd_len0),
    .cmd_ready (cmd_ready0),
    .gnt       (gnt0),
    .req       (req0),
    .beat      (beat0),
    .done      (done0),
    .err       (err0)
  );

  arb_req_chan #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid1),
    .cmd_len   (cmd_len1),
    .cmd_ready (cmd_ready1),
    .gnt       (gnt1),
    .req       (req1),
    .beat      (beat1),
    .done      (done1),
    .err       (err1)
  );

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: a scripted/random arbiter drives the grants, and a
// burst-level model predicts every output on every cycle.
module tb_arb_requester;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       cv, gn;
  logic [LEN_W-1:0] cl [2];
  logic [1:0]       rdy, rq, bt, dn, er;

  always #5 clk = ~clk;

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid0 (cv[0]),
    .cmd_len0   (cl[0]),
    .cmd_ready0 (rdy[0]),
    .cmd_valid1 (cv[1]),
    .cmd_len1   (cl[1]),
    .cmd_ready1 (rdy[1]),
    .gnt0       (gn[0]),
    .gnt1       (gn[1]),
    .req0       (rq[0]),
    .req1       (rq[1]),
    .beat0      (bt[0]),
    .beat1      (bt[1]),
    .done0      (dn[0]),
    .done1      (dn[1]),
    .err0       (er[0]),
    .err1       (er[1])
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Burst-level model: phase 0 idle, 1 asking, 2 transferring, 3 releasing.
  int m_ph [2];
  int m_left [2];
  int m_wait [2];
  bit m_done [2];
  bit m_err [2];

  // Arbiter stand-in configuration and bookkeeping.
  int a_lat [2];
  int a_drop [2];
  int a_rel [2];
  bit a_noise;
  int a_hi [2];
  int a_gc [2];
  bit a_drp [2];
  int a_lo [2];

  // Observation counters, DUT side and model side.
  int cyc;
  int d_beat [2];
  int d_done [2];
  int d_err [2];
  int d_req [2];
  int m_beat_n [2];
  int m_done_n [2];
  int m_err_n [2];
  int first_beat [2];
  int last_beat [2];
  int done_cyc [2];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      d_beat[c] = 0; d_done[c] = 0; d_err[c] = 0; d_req[c] = 0;
      m_beat_n[c] = 0; m_done_n[c] = 0; m_err_n[c] = 0;
      first_beat[c] = -1; last_beat[c] = -1; done_cyc[c] = -1;
    end
  endtask

  task automatic cfg(input int c, input int lat, input int drop, input int rel);
    a_lat[c] = lat; a_drop[c] = drop; a_rel[c] = rel;
  endtask

  task automatic model_step(input bit r, input bit [1:0] v, input bit [1:0] g,
                            input int l0, input int l1);
    for (int c = 0; c < 2; c++) begin
      m_done[c] = 0;
      m_err[c]  = 0;
      if (r) begin
        m_ph[c] = 0; m_left[c] = 0; m_wait[c] = 0;
      end else begin
        case (m_ph[c])
          0: if (v[c]) begin
               m_left[c] = ((c == 0) ? l0 : l1) + 1;
               m_wait[c] = 0;
               m_ph[c]   = 1;
             end
          1: if (g[c]) m_ph[c] = 2;
             else begin
               m_wait[c]++;
               if (m_wait[c] == TIMEOUT) begin m_err[c] = 1; m_ph[c] = 0; end
             end
          2: if (!g[c]) begin m_err[c] = 1; m_ph[c] = 0; end
             else begin
               m_left[c]--;
               if (m_left[c] == 0) begin m_ph[c] = 3; m_wait[c] = 0; end
             end
          3: if (!g[c]) begin m_done[c] = 1; m_ph[c] = 0; end
             else begin
               m_wait[c]++;
               if (m_wait[c] == TIMEOUT) begin m_err[c] = 1; m_ph[c] = 0; end
             end
          default: m_ph[c] = 0;
        endcase
      end
    end
  endtask

  task automatic arb_step();
    for (int c = 0; c < 2; c++) begin
      if (rq[c] === 1'b1) begin
        a_lo[c] = 0;
        a_hi[c]++;
        if (!a_drp[c] && a_lat[c] >= 0 && a_hi[c] > a_lat[c]) begin
          if (a_drop[c] >= 0 && a_gc[c] >= a_drop[c]) begin
            a_drp[c] = 1; gn[c] = 1'b0;
          end else begin
            gn[c] = 1'b1; a_gc[c]++;
          end
        end else begin
          gn[c] = 1'b0;
        end
      end else begin
        a_hi[c] = 0; a_gc[c] = 0; a_drp[c] = 0;
        if (gn[c] && a_lo[c] < a_rel[c]) begin
          a_lo[c]++;
          gn[c] = 1'b1;
        end else begin
          a_lo[c] = a_rel[c];
          gn[c] = a_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
      end
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, then the arbiter reacts.
  task automatic step();
    bit r_s;
    bit [1:0] v_s, g_s;
    int l0, l1;
    r_s = rst; v_s = cv; g_s = gn; l0 = int'(cl[0]); l1 = int'(cl[1]);
    @(posedge clk);
    model_step(r_s, v_s, g_s, l0, l1);
    #1;
    arb_step();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input int c, input int len);
    cv[c] = 1'b1;
    cl[c] = LEN_W'(len);
    step();
    cv[c] = 1'b0;
  endtask

  logic [9:0] exp_v, act_v;
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      for (int c = 0; c < 2; c++) begin
        exp_v[c*5 +: 5] = {m_ph[c] == 0, (m_ph[c] == 1) || (m_ph[c] == 2),
                           (m_ph[c] == 2) && (gn[c] == 1'b1), m_done[c], m_err[c]};
        act_v[c*5 +: 5] = {rdy[c], rq[c], bt[c], dn[c], er[c]};
        if (bt[c] === 1'b1) begin
          d_beat[c]++;
          if (first_beat[c] < 0) first_beat[c] = cyc;
          last_beat[c] = cyc;
        end
        if (dn[c] === 1'b1) begin d_done[c]++; done_cyc[c] = cyc; end
        if (er[c] === 1'b1) d_err[c]++;
        if (rq[c] === 1'b1) d_req[c]++;
        if (exp_v[c*5 + 2]) m_beat_n[c]++;
        if (exp_v[c*5 + 1]) m_done_n[c]++;
        if (exp_v[c*5]) m_err_n[c]++;
      end
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t {rdy,req,beat,done,err} ch1|ch0 got %b_%b, expected %b_%b",
                 $time, act_v[9:5], act_v[4:0], exp_v[9:5], exp_v[4:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; cv = '0; gn = '0; cl[0] = '0; cl[1] = '0; a_noise = 0; cyc = 0;
    for (int c = 0; c < 2; c++) begin
      m_ph[c] = 0; m_left[c] = 0; m_wait[c] = 0; m_done[c] = 0; m_err[c] = 0;
      a_hi[c] = 0; a_gc[c] = 0; a_drp[c] = 0; a_lo[c] = 0;
      cfg(c, -1, -1, 1);
    end
    clear_counts();
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(rdy), 3);
    check("reset_req_beat", int'({rq, bt}), 0);
    check("reset_done_err", int'({dn, er}), 0);

    // Single burst of 4, grant two cycles after request.
    clear_counts();
    cfg(0, 2, -1, 1);
    issue(0, 3);
    steps(25);
    check("b4_beats_dut", d_beat[0], 4);
    check("b4_beats_model", m_beat_n[0], 4);
    check("b4_req_cycles", d_req[0], 7);
    check("b4_done", d_done[0], 1);
    check("b4_err", d_err[0], 0);

    // Grant never arrives on channel 1.
    clear_counts();
    cfg(1, -1, -1, 1);
    issue(1, 0);
    steps(25);
    check("to_err_dut", d_err[1], 1);
    check("to_err_model", m_err_n[1], 1);
    check("to_req_cycles", d_req[1], 15);
    check("to_beats", d_beat[1], 0);
    check("to_ready_after", int'(rdy[1]), 1);
    check("to_req_after", int'(rq[1]), 0);

    // Grant dropped after two beats of a six-beat burst.
    clear_counts();
    cfg(0, 1, 3, 1);
    issue(0, 5);
    steps(20);
    check("drop_beats_dut", d_beat[0], 2);
    check("drop_beats_model", m_beat_n[0], 2);
    check("drop_err", d_err[0], 1);
    check("drop_done", d_done[0], 0);

    // Both channels start together; arbiter serves 0 then 1.
    clear_counts();
    cfg(0, 1, -1, 1);
    cfg(1, 8, -1, 1);
    cv = 2'b11; cl[0] = LEN_W'(1); cl[1] = LEN_W'(1);
    step();
    cv = 2'b00;
    steps(25);
    check("dual_beats0", d_beat[0], 2);
    check("dual_beats1", d_beat[1], 2);
    check("dual_done", d_done[0] + d_done[1], 2);
    check("dual_err", d_err[0] + d_err[1], 0);
    check("dual_beat_order", int'(last_beat[0] < first_beat[1]), 1);
    check("dual_done_order", int'(done_cyc[0] >= 0 && done_cyc[0] < done_cyc[1]), 1);

    // Reset in the middle of a transfer.
    clear_counts();
    cfg(0, 1, -1, 1);
    cfg(1, -1, -1, 1);
    issue(0, 5);
    for (int i = 0; i < 20 && d_beat[0] < 3; i++) step();
    check("rst_reached_beats", d_beat[0], 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_counts();
    @(negedge clk);
    check("rst_req0", int'(rq[0]), 0);
    check("rst_beat0", int'(bt[0]), 0);
    check("rst_ready0", int'(rdy[0]), 1);
    steps(10);
    check("rst_no_beats", d_beat[0], 0);
    check("rst_no_pulses", d_done[0] + d_err[0], 0);

    // Maximum length burst.
    clear_counts();
    cfg(0, 1, -1, 2);
    issue(0, 15);
    steps(30);
    check("max_beats_dut", d_beat[0], 16);
    check("max_beats_model", m_beat_n[0], 16);
    check("max_done", d_done[0], 1);
    check("max_err", d_err[0], 0);

    // Randomized traffic with a misbehaving, noisy arbiter.
    a_noise = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 40 == 0) begin
        for (int c = 0; c < 2; c++) begin
          a_lat[c]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 5));
          a_drop[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
          a_rel[c]  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 3));
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < 2; c++) begin
        cv[c] = ($urandom_range(0, 3) == 0);
        cl[c] = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      end
      step();
    end
    rst = 1'b0; cv = '0; a_noise = 0;
    steps(5);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
